// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared state type and counter widths for the SPI transaction arbiter
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_XFER,
    ST_GAP
  } state_t;

  localparam int DW_DEFAULT = 12;
  // Wide enough to hold GAP=15 plus one without wrapping.
  localparam int GAP_CW = 5;
  localparam int TMO_CW = 16;

endpackage

// File: rtl/spi_txn_arbiter_rr_pick.sv
// rtl/spi_txn_arbiter_rr_pick.sv - combinational round-robin picker
// Picks the first valid index at or after ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [IW-1:0]   id
);

  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the nearest valid index wins last.
  always_comb begin
    any = 1'b0;
    id  = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (req_valid[idx]) begin
        any = 1'b1;
        id  = idx;
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// rtl/spi_txn_arbiter.sv - round-robin arbiter sharing one SPI master among NREQ requesters
// Optional watchdog on LAUNCH/XFER enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = DW_DEFAULT,
  parameter int GAP  = 2,
  parameter int TMO  = 64,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  output logic [NREQ-1:0]  done,
  output logic [NREQ-1:0]  err,
  output logic [DW-1:0]    spi_din,
  output logic             spi_newd,
  input  logic             spi_cs,
  output logic             busy,
  output logic [IW-1:0]    grant_id
);

  if (NREQ < 2 || NREQ > 8 || GAP < 0 || GAP > 15 || TMO < 1) begin : g_cfg_check
    $error("spi_txn_arbiter: parameter out of range");
  end

  state_t            state, state_nxt;
  logic [IW-1:0]     ptr, ptr_nxt, ptr_inc, gid_nxt;
  logic [DW-1:0]     din_nxt, word;
  logic [NREQ-1:0]   ready_nxt, done_nxt, err_nxt;
  logic              newd_nxt;
  logic [GAP_CW-1:0] gap_cnt, gap_cnt_nxt;
  logic              pick_any;
  logic [IW-1:0]     pick_id;
`ifdef SPI_ARB_TIMEOUT_EN
  logic [TMO_CW-1:0] tmo_cnt, tmo_cnt_nxt;
`endif

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr),
    .any       (pick_any),
    .id        (pick_id)
  );

  always_comb begin
    word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_id == IW'(i)) word = req_data[i*DW +: DW];
    end
  end

  assign ptr_inc = (pick_id == IW'(NREQ - 1)) ? '0 : pick_id + 1'b1;

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    gid_nxt     = grant_id;
    din_nxt     = spi_din;
    newd_nxt    = spi_newd;
    ready_nxt   = '0;
    done_nxt    = '0;
    err_nxt     = '0;
    gap_cnt_nxt = gap_cnt;
`ifdef SPI_ARB_TIMEOUT_EN
    tmo_cnt_nxt = '0;
`endif
    case (state)
      // A low spi_cs means a frame may still be shifting (e.g. after reset), so never grant then.
      ST_IDLE: begin
        if (pick_any && spi_cs) begin
          ready_nxt[pick_id] = 1'b1;
          gid_nxt            = pick_id;
          din_nxt            = word;
          ptr_nxt            = ptr_inc;
          if (word == '0) begin
            err_nxt[pick_id] = 1'b1;
            newd_nxt         = 1'b0;
            gap_cnt_nxt      = '0;
            state_nxt        = ST_GAP;
          end else begin
            newd_nxt  = 1'b1;
            state_nxt = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        if (!spi_cs) begin
          newd_nxt  = 1'b0;
          state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        if (spi_cs) begin
          done_nxt[grant_id] = 1'b1;
          gap_cnt_nxt        = '0;
          state_nxt          = ST_GAP;
        end
      end
      ST_GAP: begin
        if ((gap_cnt + 1'b1) >= GAP_CW'(GAP)) begin
          state_nxt = ST_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
`ifdef SPI_ARB_TIMEOUT_EN
    // Counter restarts on every entry into LAUNCH or XFER; a normal transition wins a tie.
    if ((state == ST_LAUNCH || state == ST_XFER) && state_nxt == state) begin
      if (tmo_cnt == TMO_CW'(TMO - 1)) begin
        err_nxt[grant_id] = 1'b1;
        newd_nxt          = 1'b0;
        gap_cnt_nxt       = '0;
        state_nxt         = ST_GAP;
      end else begin
        tmo_cnt_nxt = tmo_cnt + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      grant_id  <= '0;
      spi_din   <= '0;
      spi_newd  <= 1'b0;
      req_ready <= '0;
      done      <= '0;
      err       <= '0;
      busy      <= 1'b0;
      gap_cnt   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      grant_id  <= gid_nxt;
      spi_din   <= din_nxt;
      spi_newd  <= newd_nxt;
      req_ready <= ready_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      busy      <= (state_nxt != ST_IDLE);
      gap_cnt   <= gap_cnt_nxt;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_cnt   <= tmo_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb/tb_spi_txn_arbiter.sv - self-checking bench for spi_txn_arbiter
`timescale 1ns/1ps
module tb_spi_txn_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 12;
  localparam int GAP  = 2;
  localparam int TMO  = 64;
  localparam int IW   = 2;
  localparam int GAP_EFF = (GAP == 0) ? 1 : GAP;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready, done, err;
  logic [DW-1:0]     spi_din;
  logic              spi_newd;
  logic              spi_cs;
  logic              busy;
  logic [IW-1:0]     grant_id;

  spi_txn_arbiter #(.NREQ(NREQ), .DW(DW), .GAP(GAP), .TMO(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .done      (done),
    .err       (err),
    .spi_din   (spi_din),
    .spi_newd  (spi_newd),
    .spi_cs    (spi_cs),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;

  logic              p_rst;
  logic [NREQ-1:0]   p_valid;
  logic [NREQ*DW-1:0] p_data;
  logic              p_cs;

  task automatic tick();
    p_rst   = rst_n;
    p_valid = req_valid;
    p_data  = req_data;
    p_cs    = spi_cs;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] rdy, input logic [3:0] dn,
                            input logic [3:0] er, input logic nd, input logic [11:0] din,
                            input logic bs, input logic [1:0] gid);
    check({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
    check({tag, ".done"},      32'(done),      32'(dn));
    check({tag, ".err"},       32'(err),       32'(er));
    check({tag, ".spi_newd"},  32'(spi_newd),  32'(nd));
    check({tag, ".spi_din"},   32'(spi_din),   32'(din));
    check({tag, ".busy"},      32'(busy),      32'(bs));
    check({tag, ".grant_id"},  32'(grant_id),  32'(gid));
  endtask

  // Behavioural SPI master: after seeing spi_newd it drops cs after a short delay,
  // keeps it low for a few cycles, then raises it again.
  int m_phase = 0;
  int m_cnt   = 0;

  task automatic master_step();
    case (m_phase)
      0: if (spi_newd) begin m_phase = 1; m_cnt = int'($urandom_range(2, 0)); end
      1: if (m_cnt == 0) begin spi_cs = 1'b0; m_phase = 2; m_cnt = int'($urandom_range(6, 1)); end
         else m_cnt--;
      2: if (m_cnt == 0) begin spi_cs = 1'b1; m_phase = 0; end
         else m_cnt--;
      default: m_phase = 0;
    endcase
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    spi_cs    = 1'b1;
    m_phase   = 0;
    tick();
    check("reset.busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
  endtask

  // Reference model: frame-level rules evaluated once per clock edge.
  int unsigned     mptr, mphase, mgid;
  longint          free_at;
  logic [DW-1:0]   mdin;
  logic [NREQ-1:0] e_rdy, e_dn, e_er;
  logic            e_nd, e_busy;

  task automatic model_step();
    int unsigned w;
    logic [DW-1:0] wd;
    bit found;
    e_rdy = '0; e_dn = '0; e_er = '0;
    if (!p_rst) begin
      mptr = 0; mphase = 0; mgid = 0; mdin = '0; free_at = 0;
    end else begin
      case (mphase)
        0: if (cyc >= free_at && p_cs && p_valid != '0) begin
             found = 0; w = 0;
             for (int k = 0; k < NREQ; k++) begin
               if (!found && p_valid[(mptr + k) % NREQ]) begin
                 found = 1; w = (mptr + k) % NREQ;
               end
             end
             wd = p_data[w*DW +: DW];
             e_rdy[w] = 1'b1;
             mgid = w; mdin = wd; mptr = (w + 1) % NREQ;
             if (wd == '0) begin
               e_er[w] = 1'b1;
               free_at = cyc + GAP_EFF + 1;
             end else begin
               mphase = 1;
             end
           end
        1: if (!p_cs) mphase = 2;
        default: if (p_cs) begin
             e_dn[mgid] = 1'b1;
             mphase = 0;
             free_at = cyc + GAP_EFF + 1;
           end
      endcase
    end
    e_nd   = (mphase == 1);
    e_busy = (mphase != 0) || (cyc + 1 < free_at);
  endtask

  typedef struct {
    logic            rst;
    logic [NREQ-1:0] valid;
    logic [DW-1:0]   word;
    logic            cs;
    logic [NREQ-1:0] rdy, dn, er;
    logic            nd;
    logic [DW-1:0]   din;
    logic            bs;
    logic [IW-1:0]   gid;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [3:0] v, input logic [11:0] w,
                              input logic c, input logic [3:0] rd, input logic [3:0] dn,
                              input logic [3:0] er, input logic nd, input logic [11:0] din,
                              input logic bs, input logic [1:0] g);
    vec_t t;
    t.rst = r; t.valid = v; t.word = w; t.cs = c;
    t.rdy = rd; t.dn = dn; t.er = er; t.nd = nd; t.din = din; t.bs = bs; t.gid = g;
    vecs.push_back(t);
  endfunction

  initial begin
    int grants[$];
    int dcnt[NREQ];
    bit re0;
    int id;
    logic [11:0] exp_w[5];
    int exp_g[5];

    rst_n = 1'b0; req_valid = '0; req_data = '0; spi_cs = 1'b1;

    //   rst valid word    cs  rdy  dn   er  nd din     bs gid
    add(0, 4'h1, 12'hABC, 1, 4'h0, 4'h0, 4'h0, 0, 12'h000, 0, 0);
    add(1, 4'h1, 12'hABC, 1, 4'h1, 4'h0, 4'h0, 1, 12'hABC, 1, 0);
    add(1, 4'h0, 12'hABC, 1, 4'h0, 4'h0, 4'h0, 1, 12'hABC, 1, 0);
    add(1, 4'h0, 12'hABC, 0, 4'h0, 4'h0, 4'h0, 0, 12'hABC, 1, 0);
    add(1, 4'h0, 12'hABC, 0, 4'h0, 4'h0, 4'h0, 0, 12'hABC, 1, 0);
    add(1, 4'h0, 12'hABC, 0, 4'h0, 4'h0, 4'h0, 0, 12'hABC, 1, 0);
    add(1, 4'h0, 12'hABC, 1, 4'h0, 4'h1, 4'h0, 0, 12'hABC, 1, 0);
    add(1, 4'h2, 12'h5A5, 1, 4'h0, 4'h0, 4'h0, 0, 12'hABC, 1, 0);
    add(1, 4'h2, 12'h5A5, 1, 4'h0, 4'h0, 4'h0, 0, 12'hABC, 0, 0);
    add(1, 4'h2, 12'h5A5, 1, 4'h2, 4'h0, 4'h0, 1, 12'h5A5, 1, 1);
    add(1, 4'h0, 12'h5A5, 1, 4'h0, 4'h0, 4'h0, 1, 12'h5A5, 1, 1);
    add(1, 4'h0, 12'h5A5, 0, 4'h0, 4'h0, 4'h0, 0, 12'h5A5, 1, 1);
    add(1, 4'h0, 12'h5A5, 1, 4'h0, 4'h2, 4'h0, 0, 12'h5A5, 1, 1);
    add(1, 4'h0, 12'h5A5, 1, 4'h0, 4'h0, 4'h0, 0, 12'h5A5, 1, 1);
    add(1, 4'h0, 12'h5A5, 1, 4'h0, 4'h0, 4'h0, 0, 12'h5A5, 0, 1);
    add(1, 4'h4, 12'h000, 1, 4'h4, 4'h0, 4'h4, 0, 12'h000, 1, 2);
    add(1, 4'h0, 12'h000, 1, 4'h0, 4'h0, 4'h0, 0, 12'h000, 1, 2);
    add(1, 4'h0, 12'h000, 1, 4'h0, 4'h0, 4'h0, 0, 12'h000, 0, 2);
    add(1, 4'h4, 12'h123, 1, 4'h4, 4'h0, 4'h0, 1, 12'h123, 1, 2);
    add(1, 4'h0, 12'h123, 0, 4'h0, 4'h0, 4'h0, 0, 12'h123, 1, 2);
    add(1, 4'h0, 12'h123, 1, 4'h0, 4'h4, 4'h0, 0, 12'h123, 1, 2);
    add(1, 4'h0, 12'h123, 1, 4'h0, 4'h0, 4'h0, 0, 12'h123, 1, 2);
    add(1, 4'h0, 12'h123, 1, 4'h0, 4'h0, 4'h0, 0, 12'h123, 0, 2);

    foreach (vecs[i]) begin
      rst_n     = vecs[i].rst;
      req_valid = vecs[i].valid;
      req_data  = {NREQ{vecs[i].word}};
      spi_cs    = vecs[i].cs;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].dn, vecs[i].er, vecs[i].nd,
                 vecs[i].din, vecs[i].bs, vecs[i].gid);
    end

    // All four requesters valid: order 0,1,2,3 then wrap back to 0.
    do_reset();
    exp_g = '{0, 1, 2, 3, 0};
    exp_w = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555};
    req_data  = {12'h444, 12'h333, 12'h222, 12'h111};
    req_valid = 4'hF;
    re0 = 0;
    for (int d = 0; d < NREQ; d++) dcnt[d] = 0;
    for (int c = 0; c < 400 && grants.size() < 5; c++) begin
      tick();
      for (int d = 0; d < NREQ; d++) if (done[d]) dcnt[d]++;
      if (req_ready != '0) begin
        check("rr.onehot", 32'($onehot(req_ready)), 32'd1);
        id = 0;
        for (int d = 0; d < NREQ; d++) if (req_ready[d]) id = d;
        if (grants.size() < 5) begin
          check($sformatf("rr.grant%0d", grants.size()), 32'(id), 32'(exp_g[grants.size()]));
          check($sformatf("rr.din%0d", grants.size()), 32'(spi_din), 32'(exp_w[grants.size()]));
        end
        grants.push_back(id);
        req_valid[id] = 1'b0;
        if (id == 0 && !re0) begin
          re0 = 1;
          req_valid[0] = 1'b1;
          req_data[0 +: DW] = 12'h555;
        end
      end
      master_step();
    end
    check("rr.grant_count", 32'(grants.size()), 32'd5);
    for (int c = 0; c < 40; c++) begin
      tick();
      for (int d = 0; d < NREQ; d++) if (done[d]) dcnt[d]++;
      master_step();
    end
    check("rr.done0", 32'(dcnt[0]), 32'd2);
    check("rr.done1", 32'(dcnt[1]), 32'd1);
    check("rr.done2", 32'(dcnt[2]), 32'd1);
    check("rr.done3", 32'(dcnt[3]), 32'd1);

    // Reset during XFER while the master keeps cs low.
    do_reset();
    req_valid = 4'b0001; req_data[0 +: DW] = 12'h321;
    tick();
    check("mid.grant", 32'(req_ready), 32'h1);
    req_valid = '0; spi_cs = 1'b0;
    tick(); tick();
    check("mid.xfer_newd", 32'(spi_newd), 32'd0);
    check("mid.xfer_busy", 32'(busy), 32'd1);
    rst_n = 1'b0; req_valid = 4'b0010; req_data[DW +: DW] = 12'h777;
    tick();
    check_outs("mid.rst", 4'h0, 4'h0, 4'h0, 0, 12'h000, 0, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("mid.hold_ready", 32'(req_ready), 32'd0);
      check("mid.hold_busy", 32'(busy), 32'd0);
    end
    spi_cs = 1'b1;
    tick();
    check_outs("mid.regrant", 4'h2, 4'h0, 4'h0, 1, 12'h777, 1, 1);

    // Requester 1 withdraws before grant; requester 3 wins.
    do_reset();
    spi_cs = 1'b0;
    req_valid = 4'b1010; req_data[DW +: DW] = 12'h0A1; req_data[3*DW +: DW] = 12'h0A3;
    tick();
    check("wd.blocked", 32'(req_ready), 32'd0);
    req_valid = 4'b1000; spi_cs = 1'b1;
    tick();
    check_outs("wd.grant", 4'h8, 4'h0, 4'h0, 1, 12'h0A3, 1, 3);
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("wd.no_ready1", 32'(req_ready), 32'd0);
    end

`ifdef SPI_ARB_TIMEOUT_EN
    do_reset();
    req_valid = 4'b0001; req_data[0 +: DW] = 12'h0F0;
    tick();
    check("tmo.grant", 32'(req_ready), 32'h1);
    req_valid = '0;
    for (int c = 1; c < TMO; c++) tick();
    check("tmo.early", 32'(err), 32'd0);
    tick();
    check("tmo.err", 32'(err), 32'h1);
    check("tmo.newd", 32'(spi_newd), 32'd0);
    tick(); tick();
    check("tmo.idle", 32'(busy), 32'd0);
`endif

    // Randomised traffic against the reference model.
    do_reset();
    mptr = 0; mphase = 0; mgid = 0; mdin = '0; free_at = 0;
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(599, 0) != 0);
      tick();
      model_step();
      check_outs("rnd", e_rdy, e_dn, e_er, e_nd, mdin, e_busy, 2'(mgid));
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i]) begin
          if (req_ready[i]) req_valid[i] = 1'b0;
          else if ($urandom_range(49, 0) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(3, 0) == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = ($urandom_range(7, 0) == 0) ? '0 : DW'($urandom);
        end
      end
      master_step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
